// File: rtl/rggen_bus_arbiter_pkg.sv
// Shared encodings and helpers for the rggen register-bus arbiter.
// Access/status codes match what the register-block bus adapter expects.
package rggen_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ACCESS_DEFAULT = 2'b00,
        ACCESS_READ    = 2'b10,
        ACCESS_WRITE   = 2'b11
    } access_e;

    typedef enum logic [1:0] {
        STATUS_OKAY         = 2'b00,
        STATUS_EXOKAY       = 2'b01,
        STATUS_SLAVE_ERROR  = 2'b10,
        STATUS_DECODE_ERROR = 2'b11
    } status_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Index width for n items, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rggen_bus_arbiter_if.sv
// Bundle of master-side request/response and downstream bus signals.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface rggen_bus_arbiter_if #(
    parameter int unsigned REQUESTERS    = 2,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned BUS_WIDTH     = 32
);

    logic [REQUESTERS-1:0]               i_req_valid;
    logic [2*REQUESTERS-1:0]             i_req_access;
    logic [ADDRESS_WIDTH*REQUESTERS-1:0] i_req_address;
    logic [BUS_WIDTH*REQUESTERS-1:0]     i_req_write_data;
    logic [BUS_WIDTH/8*REQUESTERS-1:0]   i_req_strobe;
    logic [REQUESTERS-1:0]               o_req_ready;
    logic [1:0]                          o_req_status;
    logic [BUS_WIDTH-1:0]                o_req_read_data;
    logic                                o_bus_valid;
    logic [1:0]                          o_bus_access;
    logic [ADDRESS_WIDTH-1:0]            o_bus_address;
    logic [BUS_WIDTH-1:0]                o_bus_write_data;
    logic [BUS_WIDTH/8-1:0]              o_bus_strobe;
    logic                                i_bus_ready;
    logic [1:0]                          i_bus_status;
    logic [BUS_WIDTH-1:0]                i_bus_read_data;
    logic [REQUESTERS-1:0]               o_grant;

    modport slave (
        input  i_req_valid, i_req_access, i_req_address, i_req_write_data, i_req_strobe,
        input  i_bus_ready, i_bus_status, i_bus_read_data,
        output o_req_ready, o_req_status, o_req_read_data,
        output o_bus_valid, o_bus_access, o_bus_address, o_bus_write_data, o_bus_strobe,
        output o_grant
    );

    modport master (
        output i_req_valid, i_req_access, i_req_address, i_req_write_data, i_req_strobe,
        output i_bus_ready, i_bus_status, i_bus_read_data,
        input  o_req_ready, o_req_status, o_req_read_data,
        input  o_bus_valid, o_bus_access, o_bus_address, o_bus_write_data, o_bus_strobe,
        input  o_grant
    );

endinterface

// File: rtl/rggen_rr_arbiter.sv
// Combinational round-robin picker: lowest set request at or above the pointer,
// else lowest set request overall (masked/unmasked double priority encode).
module rggen_rr_arbiter #(
    parameter int unsigned REQUESTERS = 2,
    parameter int unsigned PTR_WIDTH  = 1
) (
    input  logic [REQUESTERS-1:0] i_request,
    input  logic [PTR_WIDTH-1:0]  i_pointer,
    output logic [REQUESTERS-1:0] o_grant,
    output logic [PTR_WIDTH-1:0]  o_index
);

    logic [REQUESTERS-1:0] masked;
    logic [REQUESTERS-1:0] grant_masked;
    logic [REQUESTERS-1:0] grant_any;
    logic [PTR_WIDTH-1:0]  index_masked;
    logic [PTR_WIDTH-1:0]  index_any;
    logic                  found_masked;
    logic                  found_any;

    always_comb begin
        masked       = '0;
        grant_masked = '0;
        grant_any    = '0;
        index_masked = '0;
        index_any    = '0;
        found_masked = 1'b0;
        found_any    = 1'b0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            masked[i] = i_request[i] && (PTR_WIDTH'(i) >= i_pointer);
        end
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (masked[i] && !found_masked) begin
                found_masked    = 1'b1;
                index_masked    = PTR_WIDTH'(i);
                grant_masked[i] = 1'b1;
            end
            if (i_request[i] && !found_any) begin
                found_any    = 1'b1;
                index_any    = PTR_WIDTH'(i);
                grant_any[i] = 1'b1;
            end
        end
    end

    assign o_grant = found_masked ? grant_masked : grant_any;
    assign o_index = found_masked ? index_masked : index_any;

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Shares one rggen register-bus slave between REQUESTERS masters, one
// transaction at a time, with round-robin arbitration and a latched request.
module rggen_bus_arbiter
    import rggen_bus_arbiter_pkg::*;
#(
    parameter int unsigned REQUESTERS    = 2,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned BUS_WIDTH     = 32
) (
    input logic                i_clk,
    input logic                i_rst_n,
    rggen_bus_arbiter_if.slave bus_if
);

    localparam int unsigned PTR_WIDTH    = clog2(REQUESTERS);
    localparam int unsigned STROBE_WIDTH = BUS_WIDTH / 8;

    arb_state_e               state;
    logic [REQUESTERS-1:0]    grant;
    logic [PTR_WIDTH-1:0]     pointer;
    logic [1:0]               bus_access;
    logic [ADDRESS_WIDTH-1:0] bus_address;
    logic [BUS_WIDTH-1:0]     bus_write_data;
    logic [STROBE_WIDTH-1:0]  bus_strobe;
    logic [REQUESTERS-1:0]    win_grant;
    logic [PTR_WIDTH-1:0]     win_index;
    logic                     completion;

    rggen_rr_arbiter #(
        .REQUESTERS (REQUESTERS),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_rr_arbiter (
        .i_request  (bus_if.i_req_valid),
        .i_pointer  (pointer),
        .o_grant    (win_grant),
        .o_index    (win_index)
    );

    assign completion = (state == ST_BUSY) && bus_if.i_bus_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            grant          <= '0;
            pointer        <= '0;
            bus_access     <= '0;
            bus_address    <= '0;
            bus_write_data <= '0;
            bus_strobe     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus_if.i_req_valid) begin
                        state          <= ST_BUSY;
                        grant          <= win_grant;
                        // Wrap at REQUESTERS-1 so non-power-of-two counts rotate correctly.
                        pointer        <= (win_index == PTR_WIDTH'(REQUESTERS - 1)) ? '0 : win_index + 1'b1;
                        bus_access     <= bus_if.i_req_access[2*win_index +: 2];
                        bus_address    <= bus_if.i_req_address[ADDRESS_WIDTH*win_index +: ADDRESS_WIDTH];
                        bus_write_data <= bus_if.i_req_write_data[BUS_WIDTH*win_index +: BUS_WIDTH];
                        bus_strobe     <= bus_if.i_req_strobe[STROBE_WIDTH*win_index +: STROBE_WIDTH];
                    end
                end
                ST_BUSY: begin
                    if (bus_if.i_bus_ready) begin
                        state <= ST_IDLE;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign bus_if.o_bus_valid      = (state == ST_BUSY);
    assign bus_if.o_bus_access     = bus_access;
    assign bus_if.o_bus_address    = bus_address;
    assign bus_if.o_bus_write_data = bus_write_data;
    assign bus_if.o_bus_strobe     = bus_strobe;
    assign bus_if.o_grant          = grant;

    // Response passes through only in the completing cycle; zero otherwise.
    assign bus_if.o_req_ready      = completion ? grant : '0;
    assign bus_if.o_req_status     = completion ? bus_if.i_bus_status : '0;
    assign bus_if.o_req_read_data  = completion ? bus_if.i_bus_read_data : '0;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed bench: per-cycle vector table on a 2-master arbiter, plus
// rotation sequences on a 3-master arbiter.
module tb_rggen_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rggen_bus_arbiter_if #(.REQUESTERS(2), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bif2 ();
    rggen_bus_arbiter_if #(.REQUESTERS(3), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bif3 ();

    rggen_bus_arbiter #(.REQUESTERS(2), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) u_dut2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus_if  (bif2)
    );

    rggen_bus_arbiter #(.REQUESTERS(3), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) u_dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus_if  (bif3)
    );

    typedef struct {
        logic        rst_n;
        logic [1:0]  valid;
        logic [3:0]  access;
        logic [15:0] address;
        logic [63:0] wdata;
        logic [7:0]  strobe;
        logic        bus_ready;
        logic [1:0]  bus_status;
        logic [31:0] bus_rdata;
        logic        e_valid;
        logic [1:0]  e_access;
        logic [7:0]  e_address;
        logic [31:0] e_wdata;
        logic [3:0]  e_strobe;
        logic [1:0]  e_grant;
        logic [1:0]  e_ready;
        logic [1:0]  e_status;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(
        input logic r, input logic [1:0] v, input logic [3:0] a, input logic [15:0] ad,
        input logic [63:0] wd, input logic [7:0] st, input logic br, input logic [1:0] bs,
        input logic [31:0] bd, input logic ev, input logic [1:0] ea, input logic [7:0] ead,
        input logic [31:0] ewd, input logic [3:0] est, input logic [1:0] eg, input logic [1:0] er,
        input logic [1:0] es, input logic [31:0] ed
    );
        vec_t t;
        t = '{r, v, a, ad, wd, st, br, bs, bd, ev, ea, ead, ewd, est, eg, er, es, ed};
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    localparam logic [63:0] WD  = 64'h0000_0000_1234_5678;
    localparam logic [63:0] WD2 = 64'h0000_0000_AAAA_5555;

    int order_all[6] = '{0, 1, 2, 0, 1, 2};
    int order_02[4]  = '{0, 2, 0, 2};

    initial begin
        //  rst valid  access   addr      wdata strb  rdy stat bus_rdata       ev acc    addr   wdata         strb  grant  ready  stat   rdata
        add(0, 2'b00, 4'h0,    16'h0000, 0,    8'h0, 0, 2'b00, 32'h0,          0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);
        add(1, 2'b00, 4'h0,    16'h0000, 0,    8'h0, 0, 2'b00, 32'h0,          0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);
        // master1 read of 0x10, ready on third busy cycle
        add(1, 2'b10, 4'b1000, 16'h1000, 0,    8'h0, 0, 2'b00, 32'h0,          0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);
        add(1, 2'b10, 4'b1000, 16'h1000, 0,    8'h0, 0, 2'b00, 32'h0,          1, 2'b10, 8'h10, 32'h0,        4'h0, 2'b10, 2'b00, 2'b00, 32'h0);
        add(1, 2'b10, 4'b1000, 16'h1000, 0,    8'h0, 0, 2'b00, 32'h0,          1, 2'b10, 8'h10, 32'h0,        4'h0, 2'b10, 2'b00, 2'b00, 32'h0);
        add(1, 2'b10, 4'b1000, 16'h1000, 0,    8'h0, 1, 2'b00, 32'hDEADBEEF,   1, 2'b10, 8'h10, 32'h0,        4'h0, 2'b10, 2'b10, 2'b00, 32'hDEADBEEF);
        add(1, 2'b00, 4'h0,    16'h0000, 0,    8'h0, 0, 2'b00, 32'h0,          0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);
        // master0 write; inputs change after grant
        add(1, 2'b01, 4'b0011, 16'h0020, WD,   8'h0F, 0, 2'b00, 32'h0,         0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);
        add(1, 2'b01, 4'b0011, 16'h0020, WD,   8'h0F, 0, 2'b00, 32'h0,         1, 2'b11, 8'h20, 32'h12345678, 4'hF, 2'b01, 2'b00, 2'b00, 32'h0);
        add(1, 2'b00, 4'b0011, 16'h0044, WD2,  8'h00, 0, 2'b00, 32'h0,         1, 2'b11, 8'h20, 32'h12345678, 4'hF, 2'b01, 2'b00, 2'b00, 32'h0);
        add(1, 2'b00, 4'b0011, 16'h0044, WD2,  8'h00, 0, 2'b00, 32'h0,         1, 2'b11, 8'h20, 32'h12345678, 4'hF, 2'b01, 2'b00, 2'b00, 32'h0);
        add(1, 2'b00, 4'b0011, 16'h0044, WD2,  8'h00, 1, 2'b00, 32'h0,         1, 2'b11, 8'h20, 32'h12345678, 4'hF, 2'b01, 2'b01, 2'b00, 32'h0);
        add(1, 2'b00, 4'h0,    16'h0000, 0,    8'h0, 0, 2'b00, 32'h0,          0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);
        // error response with ready in the first busy cycle; forced to 0 afterwards
        add(1, 2'b01, 4'b0010, 16'h0030, 0,    8'h0, 0, 2'b00, 32'h0,          0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);
        add(1, 2'b01, 4'b0010, 16'h0030, 0,    8'h0, 1, 2'b10, 32'hFFFFFFFF,   1, 2'b10, 8'h30, 32'h0,        4'h0, 2'b01, 2'b01, 2'b10, 32'hFFFFFFFF);
        add(1, 2'b00, 4'h0,    16'h0000, 0,    8'h0, 1, 2'b10, 32'hFFFFFFFF,   0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);
        // pointer at 1: both request, master1 wins, then master0
        add(1, 2'b11, 4'b1010, 16'h0201, 0,    8'h0, 0, 2'b00, 32'h0,          0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);
        add(1, 2'b11, 4'b1010, 16'h0201, 0,    8'h0, 0, 2'b00, 32'h0,          1, 2'b10, 8'h02, 32'h0,        4'h0, 2'b10, 2'b00, 2'b00, 32'h0);
        add(1, 2'b11, 4'b1010, 16'h0201, 0,    8'h0, 1, 2'b01, 32'h11111111,   1, 2'b10, 8'h02, 32'h0,        4'h0, 2'b10, 2'b10, 2'b01, 32'h11111111);
        add(1, 2'b01, 4'b1010, 16'h0201, 0,    8'h0, 0, 2'b00, 32'h0,          0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);
        add(1, 2'b01, 4'b1010, 16'h0201, 0,    8'h0, 0, 2'b00, 32'h0,          1, 2'b10, 8'h01, 32'h0,        4'h0, 2'b01, 2'b00, 2'b00, 32'h0);
        // async reset mid-busy with ready asserted: no pulse, pointer back to 0
        add(0, 2'b01, 4'b1010, 16'h0201, 0,    8'h0, 1, 2'b10, 32'hFFFFFFFF,   0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);
        add(1, 2'b11, 4'b1010, 16'h0201, 0,    8'h0, 0, 2'b00, 32'h0,          0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);
        add(1, 2'b11, 4'b1010, 16'h0201, 0,    8'h0, 0, 2'b00, 32'h0,          1, 2'b10, 8'h01, 32'h0,        4'h0, 2'b01, 2'b00, 2'b00, 32'h0);
        add(1, 2'b11, 4'b1010, 16'h0201, 0,    8'h0, 1, 2'b00, 32'h000000A5,   1, 2'b10, 8'h01, 32'h0,        4'h0, 2'b01, 2'b01, 2'b00, 32'h000000A5);
        add(1, 2'b10, 4'b1010, 16'h0201, 0,    8'h0, 0, 2'b00, 32'h0,          0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);
        add(1, 2'b10, 4'b1010, 16'h0201, 0,    8'h0, 1, 2'b00, 32'h0000005A,   1, 2'b10, 8'h02, 32'h0,        4'h0, 2'b10, 2'b10, 2'b00, 32'h0000005A);
        add(1, 2'b00, 4'h0,    16'h0000, 0,    8'h0, 0, 2'b00, 32'h0,          0, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 2'b00, 2'b00, 32'h0);

        bif3.i_req_valid      = '0;
        bif3.i_req_access     = {2'b10, 2'b10, 2'b10};
        bif3.i_req_address    = {8'h0C, 8'h0B, 8'h0A};
        bif3.i_req_write_data = '0;
        bif3.i_req_strobe     = '0;
        bif3.i_bus_ready      = 1'b0;
        bif3.i_bus_status     = 2'b00;
        bif3.i_bus_read_data  = '0;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst_n                 = vecs[i].rst_n;
            bif2.i_req_valid      = vecs[i].valid;
            bif2.i_req_access     = vecs[i].access;
            bif2.i_req_address    = vecs[i].address;
            bif2.i_req_write_data = vecs[i].wdata;
            bif2.i_req_strobe     = vecs[i].strobe;
            bif2.i_bus_ready      = vecs[i].bus_ready;
            bif2.i_bus_status     = vecs[i].bus_status;
            bif2.i_bus_read_data  = vecs[i].bus_rdata;
            #3;
            check("bus_valid", i, 64'(bif2.o_bus_valid), 64'(vecs[i].e_valid));
            check("grant", i, 64'(bif2.o_grant), 64'(vecs[i].e_grant));
            check("req_ready", i, 64'(bif2.o_req_ready), 64'(vecs[i].e_ready));
            check("req_status", i, 64'(bif2.o_req_status), 64'(vecs[i].e_status));
            check("req_read_data", i, 64'(bif2.o_req_read_data), 64'(vecs[i].e_rdata));
            if (vecs[i].e_valid) begin
                check("bus_access", i, 64'(bif2.o_bus_access), 64'(vecs[i].e_access));
                check("bus_address", i, 64'(bif2.o_bus_address), 64'(vecs[i].e_address));
                check("bus_write_data", i, 64'(bif2.o_bus_write_data), 64'(vecs[i].e_wdata));
                check("bus_strobe", i, 64'(bif2.o_bus_strobe), 64'(vecs[i].e_strobe));
            end
        end

        // three masters always requesting, ready tied high: 0,1,2,0,1,2
        for (int j = 0; j < 12; j++) begin
            logic [2:0] exp_g;
            @(posedge clk);
            #1;
            bif3.i_req_valid = 3'b111;
            bif3.i_bus_ready = 1'b1;
            #3;
            exp_g = (j % 2 == 1) ? 3'(1 << order_all[j / 2]) : 3'b000;
            check("rr3_bus_valid", j, 64'(bif3.o_bus_valid), 64'(j % 2));
            check("rr3_grant", j, 64'(bif3.o_grant), 64'(exp_g));
            check("rr3_req_ready", j, 64'(bif3.o_req_ready), 64'(exp_g));
            if (j % 2 == 1) begin
                check("rr3_address", j, 64'(bif3.o_bus_address), 64'(8'h0A + order_all[j / 2]));
            end
        end

        // masters 0 and 2 only: 0,2,0,2 and master 1 never granted
        for (int j = 0; j < 8; j++) begin
            logic [2:0] exp_g;
            @(posedge clk);
            #1;
            bif3.i_req_valid = 3'b101;
            #3;
            exp_g = (j % 2 == 1) ? 3'(1 << order_02[j / 2]) : 3'b000;
            check("rr02_bus_valid", j, 64'(bif3.o_bus_valid), 64'(j % 2));
            check("rr02_grant", j, 64'(bif3.o_grant), 64'(exp_g));
            check("rr02_req_ready", j, 64'(bif3.o_req_ready), 64'(exp_g));
        end

        @(posedge clk);
        #1;
        bif3.i_req_valid = '0;
        bif3.i_bus_ready = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rggen_bus_arbiter.md
Name: rggen_bus_arbiter

Overview:
Shares one rggen register-bus slave port (a register-block adapter) between N bus masters, e.g. host bridge, debug UART and on-chip sequencer.
Arbitration is round-robin with one transaction granted at a time.
The granted request is latched and presented downstream until the slave returns ready; the response is routed back to the winner.
The block sits between the master-side bus bridges and the register block's bus adapter.

Parameters:
REQUESTERS, 2, number of masters (>=1)
ADDRESS_WIDTH, 8, bus address width
BUS_WIDTH, 32, data width (multiple of 8)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_req_valid  in  REQUESTERS  per-master request valid
i_req_access  in  2*REQUESTERS  per-master access code, master k at [2k+:2]
i_req_address  in  ADDRESS_WIDTH*REQUESTERS  per-master address, packed as above
i_req_write_data  in  BUS_WIDTH*REQUESTERS  per-master write data
i_req_strobe  in  BUS_WIDTH/8*REQUESTERS  per-master byte strobes
o_req_ready  out  REQUESTERS  one-hot completion pulse to the granted master
o_req_status  out  2  response status, shared, qualified by o_req_ready
o_req_read_data  out  BUS_WIDTH  response read data, shared, qualified by o_req_ready
o_bus_valid  out  1  downstream request valid
o_bus_access  out  2  latched access code
o_bus_address  out  ADDRESS_WIDTH  latched address
o_bus_write_data  out  BUS_WIDTH  latched write data
o_bus_strobe  out  BUS_WIDTH/8  latched strobes
i_bus_ready  in  1  downstream completion; may be high in the first valid cycle
i_bus_status  in  2  downstream status
i_bus_read_data  in  BUS_WIDTH  downstream read data
o_grant  out  REQUESTERS  one-hot current grant, for debug and observability

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: state IDLE, grant 0, RR pointer 0, latched request fields 0. This gives o_bus_valid=0, o_req_ready=0, o_grant=0, o_req_status=0, o_req_read_data=0.
- FSM, IDLE -> BUSY: in IDLE, if any i_req_valid is set, pick a winner on the next edge and go BUSY.
  - Winner: the first set bit at or after the RR pointer, searching upward with wrap.
  - The same edge latches the winner's access, address, write_data and strobe.
  - The same edge sets grant=onehot(winner) and pointer=(winner+1) mod REQUESTERS.
- BUSY outputs: o_bus_valid=1 and o_bus_* are driven from the latch only. Master inputs changing or dropping after grant have no effect.
- Completion: while BUSY and i_bus_ready=1, in the same cycle (combinational):
  - o_req_ready = grant.
  - o_req_status = i_bus_status.
  - o_req_read_data = i_bus_read_data.
- BUSY -> IDLE: on the completion edge, go IDLE and clear grant. With no completion, stay BUSY indefinitely (no timeout).
- Idle response outputs: o_req_ready=0, and status/read_data are forced to 0 when not completing.
- Latency and throughput: request to o_bus_valid is 1 cycle. Minimum 2 cycles per transaction (IDLE arbitration cycle + BUSY cycle); no back-to-back grants.
- Master protocol: a master holds valid until it sees its ready bit, then may drop valid or present a new request the following cycle.
  - A master may withdraw before grant.
  - Because the pointer has already moved past the winner, a master that has just completed re-requesting has lowest priority.
- REQUESTERS=1: arbitration degenerates to that master; timing is unchanged.
- Mid-transaction reset: o_bus_valid and o_grant drop asynchronously and the pointer returns to 0. The downstream slave is reset from the same i_rst_n.
- Width rules: pointer width is clog2(REQUESTERS), minimum 1. Wrap compares against REQUESTERS-1, not a power of two.

Decomposition:
- Shared package/include: access encodings (READ/WRITE/DEFAULT), status encodings (OKAY 2'b00, EXOKAY 2'b01, SLAVE_ERROR 2'b10, DECODE_ERROR 2'b11), and the clog2 helper function.
- One sub-module, rggen_rr_arbiter: a combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner, winner index.
  - Implemented as a masked/unmasked double priority encode.
- FSM, latch and response routing stay in rggen_bus_arbiter.

Test Plan:
1. N=2: master1 reads 0x10 at cycle 0; downstream ready at cycle 3 with status 00, data 0xDEADBEEF. Expect o_bus_valid cycles 1-3, address 0x10; o_req_ready=2'b10 at cycle 3 only, with read data 0xDEADBEEF.
2. N=3: all three valid continuously from reset, ready tied high. Expect grant order 0,1,2,0,1,2, one transaction per 2 cycles, o_bus_valid alternating 0/1.
3. N=3: masters 0 and 2 continuously valid. Expect grants alternating 0,2,0,2; master 1 is never granted.
4. Master0 writes 0x20/0x12345678 with strobe 0xF, then changes address to 0x44 and drops valid one cycle after grant, with ready at cycle 4. Expect o_bus_address=0x20 and write data unchanged through cycle 4, then completion.
5. Downstream returns status 2'b10 with data 0xFFFFFFFF. Expect o_req_status=2'b10 and o_req_read_data=0xFFFFFFFF with the ready pulse, and 0 the next cycle.
6. Assert i_rst_n low mid-BUSY, before ready. Expect o_bus_valid and o_grant to go 0 immediately with no ready pulse; after release, master1 is served first only if master0 is idle (pointer back to 0).
